conv_layer_sequencer: RTL and testbench
=======================================

# conv_layer_sequencer

Control FSM that runs one convolution/matmul layer on the systolic datapath by splitting the weight matrix's output columns into array-width tiles. For each tile it starts the weight cache, waits for the cached indication, then starts the img2col stream and counts output beats. After the last tile it raises `done`. It sits between the layer-level host/DMA control and the `Weight_Cache` / `Img2ColStream` pair, and replaces their hand-driven `start` wiring.

## Interface
- `ARRAY_COLS`, 8: output columns the array computes per tile.
- `ROW_W`, 16: width of the row and column configuration fields.
- `OUT_W`, 32: width of the output-row count and beat counter.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle layer start request.
- `abort` in 1: synchronous cancel of the current layer.
- `cfg_matrix_row` in ROW_W: K·K·Cin (rows of the weight matrix).
- `cfg_matrix_col` in ROW_W: Cout (total output columns).
- `cfg_out_rows` in OUT_W: output pixels, i.e. beats per tile.
- `wc_start` out 1: one-cycle start pulse to the weight cache.
- `wc_matrix_row` out ROW_W: latched copy of `cfg_matrix_row`.
- `wc_matrix_col` out ROW_W: column count of the current tile.
- `wc_out_rows` out OUT_W: latched copy of `cfg_out_rows`.
- `wc_layer_end` out 1: high for the whole of the last tile.
- `wc_weight_cached` in 1: weight cache reports the tile's weights are loaded.
- `i2c_start` out 1: one-cycle start pulse to the img2col stream.
- `out_valid`, `out_ready` in 1: monitored output handshake.
- `tile_idx` out ROW_W: index of the current tile.
- `busy` out 1: a layer is in progress.
- `done` out 1: one-cycle pulse when the layer completes.
- `cfg_err` out 1: one-cycle pulse when a start is rejected.

## Operation
- **States:** IDLE, LOAD_W, WAIT_W, STREAM, NEXT.
- **IDLE, on `start`:**
  - If any of `cfg_matrix_row`, `cfg_matrix_col`, `cfg_out_rows` is zero: pulse `cfg_err` and stay in IDLE.
  - Otherwise: latch all cfg inputs, set `tile_idx`=0 and remaining = `cfg_matrix_col`, then go to LOAD_W.
- **Tile width:** `wc_matrix_col` = min(ARRAY_COLS, remaining). Remainder tiles are narrower, e.g. Cout=20 gives tiles of 8, 8, 4.
- **LOAD_W:** `wc_start`=1 for exactly this one cycle, then go to WAIT_W.
- **WAIT_W:** wait for `wc_weight_cached`=1, then go to STREAM. A `wc_weight_cached` level that was already high while in LOAD_W is not counted.
- **STREAM:**
  - `i2c_start`=1 on the first cycle only.
  - The beat counter increments on each `out_valid && out_ready`.
  - When the counter reaches `wc_out_rows`, go to NEXT.
  - Handshakes outside STREAM are ignored and not counted.
- **NEXT:**
  - remaining -= tile width.
  - If remaining = 0: pulse `done`, go to IDLE.
  - Otherwise: `tile_idx`+1, clear the beat counter, go to LOAD_W.
- **`wc_layer_end`:** equals (remaining ≤ ARRAY_COLS) while `busy`.
- **`abort`:** from any non-IDLE state, go to IDLE on the next edge with no `done` pulse and counters cleared. `abort` wins over a simultaneous final beat.
- **`start` while busy:** ignored, and the latched config is unchanged.

## Timing
- **Reset values:** every output is 0, state is IDLE, counters are 0.
- **Reset mid-layer:** returns to IDLE immediately (asynchronously); no `done`.
- **Start to weight load:** `start` at cycle T gives `busy`=1 and `wc_start`=1 at T+1.
- **Weight cached to stream:** `wc_weight_cached` seen at cycle C gives `i2c_start` at C+1.
- **Last beat to next step:** final beat at cycle B gives NEXT at B+1. Then either `done` at B+1 with `busy`=0 from B+2, or the next tile's `wc_start` at B+2.
- **Pulse widths:** `done`, `wc_start`, `i2c_start` and `cfg_err` are never wider than one cycle.
- **Counter width:** the beat counter is OUT_W bits and compares for equality; overflow is impossible because counts are bounded by `cfg_out_rows`.

## Structure
- Shared package `conv_seq_pkg`:
  - state enum with the state names above;
  - `ARRAY_COLS_DEFAULT`;
  - the cfg record type (matrix_row, matrix_col, out_rows).
- One sub-module, `tile_beat_counter`: counts the handshake beats, clears on tile start, and outputs `tile_last_beat`.
- The FSM and the remaining/tile-width arithmetic live in the top module.

## Test plan
- **Nominal layer:** cfg 288/32/49729 with ARRAY_COLS=8.
  - Expect 4 `wc_start` pulses, `wc_matrix_col`=8 each time, and `tile_idx` going 0..3.
  - Expect `wc_layer_end` only during tile 3, and a single `done` after 4×49729 beats.
- **Remainder tile:** Cout=20, out_rows=5.
  - Expect tile widths 8, 8, 4 and `done` 1 cycle after the 15th counted beat.
- **Bad config:** `start` with `cfg_out_rows`=0.
  - Expect `cfg_err` for 1 cycle, `busy` staying 0, and no `wc_start`.
- **Abort with final beat:** `abort` asserted in the same cycle as the final beat of tile 1.
  - Expect IDLE next cycle with no `done`.
  - A following `start` restarts from `tile_idx`=0.
- **Async reset mid-layer:** reset pulse during WAIT_W.
  - Expect all outputs 0 within the reset pulse, before the next clock edge.
  - Handshake beats during reset are not counted.
- **Ignored inputs:**
  - `start` pulse during STREAM is ignored.
  - Handshakes during WAIT_W are ignored, so the beat count is exactly `cfg_out_rows` per tile.

Source files
------------

// File: rtl/conv_seq_pkg.sv
// Shared types for the convolution layer sequencer.
//   seq_state_e  : sequencer FSM states
//   layer_cfg_t  : layer configuration record (matrix_row, matrix_col, out_rows)
//   ARRAY_COLS_DEFAULT / ROW_W_DEFAULT / OUT_W_DEFAULT : default geometry
package conv_seq_pkg;

   localparam int ARRAY_COLS_DEFAULT = 8;
   localparam int ROW_W_DEFAULT      = 16;
   localparam int OUT_W_DEFAULT      = 32;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD_W = 3'd1,
      WAIT_W = 3'd2,
      STREAM = 3'd3,
      NEXT   = 3'd4
   } seq_state_e;

   typedef struct packed {
      logic [ROW_W_DEFAULT-1:0] matrix_row;
      logic [ROW_W_DEFAULT-1:0] matrix_col;
      logic [OUT_W_DEFAULT-1:0] out_rows;
   } layer_cfg_t;

endpackage

// File: rtl/tile_beat_counter.sv
// Counts accepted output beats (valid && ready) within one tile.
//   clk, reset      : clock, async active-high reset
//   clear           : synchronous clear (outside streaming, or on abort)
//   enable          : beats are only counted while high
//   out_valid/ready : monitored output handshake
//   out_rows        : beats expected in the tile (never zero)
//   tile_last_beat  : high in the cycle the final beat of the tile is accepted
import conv_seq_pkg::*;

module tile_beat_counter #(
   parameter int OUT_W = OUT_W_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             enable,
   input  logic             out_valid,
   input  logic             out_ready,
   input  logic [OUT_W-1:0] out_rows,
   output logic             tile_last_beat
);

   localparam logic [OUT_W-1:0] ONE = OUT_W'(1);

   logic [OUT_W-1:0] beat_count;
   logic             beat;

   assign beat = enable && out_valid && out_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         beat_count <= '0;
      else if (clear)
         beat_count <= '0;
      else if (beat)
         beat_count <= beat_count + ONE;
   end

   // Flag the final beat as it is accepted so the FSM leaves on the next edge.
   assign tile_last_beat = beat && (beat_count == (out_rows - ONE));

endmodule

// File: rtl/conv_layer_sequencer.sv
// Runs one conv/matmul layer by splitting Cout into ARRAY_COLS-wide tiles:
// per tile it starts the weight cache, waits for the cached indication,
// starts the img2col stream and counts output beats; done after last tile.
//   start/abort            : layer start request / synchronous cancel
//   cfg_*                  : layer configuration, latched on accepted start
//   wc_*                   : weight cache control and tile geometry
//   wc_weight_cached       : weight cache has loaded the current tile
//   i2c_start              : img2col stream start pulse
//   out_valid/out_ready    : monitored output handshake
//   tile_idx/busy/done     : progress status
//   cfg_err                : start rejected because a cfg field was zero
//
// state  | meaning
// IDLE   | no layer; waiting for start
// LOAD_W | wc_start pulse for the current tile
// WAIT_W | waiting for wc_weight_cached
// STREAM | img2col running; counting output beats
// NEXT   | tile finished; advance tile or finish layer
import conv_seq_pkg::*;

module conv_layer_sequencer #(
   parameter int ARRAY_COLS = ARRAY_COLS_DEFAULT,
   parameter int ROW_W      = ROW_W_DEFAULT,
   parameter int OUT_W      = OUT_W_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic [ROW_W-1:0] cfg_matrix_row,
   input  logic [ROW_W-1:0] cfg_matrix_col,
   input  logic [OUT_W-1:0] cfg_out_rows,
   output logic             wc_start,
   output logic [ROW_W-1:0] wc_matrix_row,
   output logic [ROW_W-1:0] wc_matrix_col,
   output logic [OUT_W-1:0] wc_out_rows,
   output logic             wc_layer_end,
   input  logic             wc_weight_cached,
   output logic             i2c_start,
   input  logic             out_valid,
   input  logic             out_ready,
   output logic [ROW_W-1:0] tile_idx,
   output logic             busy,
   output logic             done,
   output logic             cfg_err
);

   localparam logic [ROW_W-1:0] COLS_W  = ROW_W'(ARRAY_COLS);
   localparam logic [ROW_W-1:0] ONE_ROW = ROW_W'(1);

   seq_state_e       state;
   layer_cfg_t       cfg_in;
   logic [ROW_W-1:0] remaining;
   logic [ROW_W-1:0] tile_w;
   logic             cfg_bad;
   logic             last_tile;
   logic             tile_last_beat;

   assign cfg_in.matrix_row = cfg_matrix_row;
   assign cfg_in.matrix_col = cfg_matrix_col;
   assign cfg_in.out_rows   = cfg_out_rows;

   assign cfg_bad = (cfg_in.matrix_row == '0) || (cfg_in.matrix_col == '0) ||
                    (cfg_in.out_rows == '0);

   // remaining is zero whenever idle, so the tile width reads zero there too.
   assign tile_w        = (remaining < COLS_W) ? remaining : COLS_W;
   assign last_tile     = (remaining <= COLS_W);
   assign wc_matrix_col = tile_w;
   assign wc_layer_end  = busy && last_tile;

   tile_beat_counter #(.OUT_W(OUT_W)) u_beat_cnt (
      .clk            (clk),
      .reset          (reset),
      .clear          ((state != STREAM) || abort),
      .enable         (state == STREAM),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_rows       (wc_out_rows),
      .tile_last_beat (tile_last_beat)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         remaining     <= '0;
         tile_idx      <= '0;
         wc_matrix_row <= '0;
         wc_out_rows   <= '0;
         busy          <= 1'b0;
         wc_start      <= 1'b0;
         i2c_start     <= 1'b0;
         done          <= 1'b0;
         cfg_err       <= 1'b0;
      end else begin
         wc_start  <= 1'b0;
         i2c_start <= 1'b0;
         done      <= 1'b0;
         cfg_err   <= 1'b0;

         // abort has priority over everything, including a final beat.
         if (abort && (state != IDLE)) begin
            state     <= IDLE;
            remaining <= '0;
            tile_idx  <= '0;
            busy      <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     if (cfg_bad) begin
                        cfg_err <= 1'b1;
                     end else begin
                        wc_matrix_row <= cfg_in.matrix_row;
                        wc_out_rows   <= cfg_in.out_rows;
                        remaining     <= cfg_in.matrix_col;
                        tile_idx      <= '0;
                        busy          <= 1'b1;
                        wc_start      <= 1'b1;
                        state         <= LOAD_W;
                     end
                  end
               end
               // wc_weight_cached is deliberately not sampled here: a level
               // left over from the previous tile must not skip the wait.
               LOAD_W: state <= WAIT_W;
               WAIT_W: begin
                  if (wc_weight_cached) begin
                     i2c_start <= 1'b1;
                     state     <= STREAM;
                  end
               end
               STREAM: begin
                  if (tile_last_beat) begin
                     done  <= last_tile;
                     state <= NEXT;
                  end
               end
               NEXT: begin
                  remaining <= remaining - tile_w;
                  if (last_tile) begin
                     tile_idx <= '0;
                     busy     <= 1'b0;
                     state    <= IDLE;
                  end else begin
                     tile_idx <= tile_idx + ONE_ROW;
                     wc_start <= 1'b1;
                     state    <= LOAD_W;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Self-checking bench for conv_layer_sequencer. Drives whole layers with
// randomized handshakes and compares against a tile-list model of the layer.
module tb_conv_layer_sequencer;

   localparam int ARRAY_COLS = 8;
   localparam int ROW_W      = 16;
   localparam int OUT_W      = 32;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             start = 1'b0;
   logic             abort = 1'b0;
   logic [ROW_W-1:0] cfg_matrix_row = '0;
   logic [ROW_W-1:0] cfg_matrix_col = '0;
   logic [OUT_W-1:0] cfg_out_rows = '0;
   logic             wc_start;
   logic [ROW_W-1:0] wc_matrix_row;
   logic [ROW_W-1:0] wc_matrix_col;
   logic [OUT_W-1:0] wc_out_rows;
   logic             wc_layer_end;
   logic             wc_weight_cached = 1'b0;
   logic             i2c_start;
   logic             out_valid = 1'b0;
   logic             out_ready = 1'b0;
   logic [ROW_W-1:0] tile_idx;
   logic             busy;
   logic             done;
   logic             cfg_err;

   int n_pass  = 0;
   int n_total = 0;

   conv_layer_sequencer #(.ARRAY_COLS(ARRAY_COLS), .ROW_W(ROW_W), .OUT_W(OUT_W)) dut (
      .clk              (clk),
      .reset            (reset),
      .start            (start),
      .abort            (abort),
      .cfg_matrix_row   (cfg_matrix_row),
      .cfg_matrix_col   (cfg_matrix_col),
      .cfg_out_rows     (cfg_out_rows),
      .wc_start         (wc_start),
      .wc_matrix_row    (wc_matrix_row),
      .wc_matrix_col    (wc_matrix_col),
      .wc_out_rows      (wc_out_rows),
      .wc_layer_end     (wc_layer_end),
      .wc_weight_cached (wc_weight_cached),
      .i2c_start        (i2c_start),
      .out_valid        (out_valid),
      .out_ready        (out_ready),
      .tile_idx         (tile_idx),
      .busy             (busy),
      .done             (done),
      .cfg_err          (cfg_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [85:0] all_outs();
      return {wc_start, wc_matrix_row, wc_matrix_col, wc_out_rows, wc_layer_end,
              i2c_start, tile_idx, busy, done, cfg_err};
   endfunction

   // Runs one layer end to end. abort_tile >= 0 aborts on that tile's final
   // beat; poke_start pulses start (with altered cfg) mid-stream in tile 0;
   // hs_in_wait drives handshakes while waiting for the weight cache.
   task automatic run_layer(input int row, input int col, input int orows,
                            input int abort_tile, input bit poke_start,
                            input bit hs_in_wait, input string tag);
      int widths[$];
      int rem, w, n, beats, guard;
      bit early, v, r, fin, saw_i2c;
      rem = col;
      while (rem > 0) begin
         w = (rem > ARRAY_COLS) ? ARRAY_COLS : rem;
         widths.push_back(w);
         rem -= w;
      end
      n = widths.size();

      cfg_matrix_row = ROW_W'(row);
      cfg_matrix_col = ROW_W'(col);
      cfg_out_rows   = OUT_W'(orows);
      start = 1'b1;
      tick();
      start = 1'b0;
      n_total++;
      if (busy !== 1'b1) $display("FAIL %s busy_after_start: got %0b want 1", tag, busy);
      else n_pass++;

      for (int t = 0; t < n; t++) begin
         n_total++;
         if (wc_start !== 1'b1) begin
            $display("FAIL %s wc_start_tile%0d: got %0b want 1", tag, t, wc_start);
            return;
         end else n_pass++;
         n_total++;
         if (tile_idx !== ROW_W'(t)) $display("FAIL %s tile_idx: got %0d want %0d", tag, tile_idx, t);
         else n_pass++;
         n_total++;
         if (wc_matrix_col !== ROW_W'(widths[t]))
            $display("FAIL %s tile_width%0d: got %0d want %0d", tag, t, wc_matrix_col, widths[t]);
         else n_pass++;
         n_total++;
         if (wc_layer_end !== (t == n - 1))
            $display("FAIL %s layer_end%0d: got %0b want %0b", tag, t, wc_layer_end, (t == n - 1));
         else n_pass++;
         n_total++;
         if (wc_matrix_row !== ROW_W'(row) || wc_out_rows !== OUT_W'(orows))
            $display("FAIL %s latched_cfg: got %0d/%0d want %0d/%0d", tag, wc_matrix_row, wc_out_rows, row, orows);
         else n_pass++;

         // cached already high during LOAD_W must not count
         wc_weight_cached = 1'b1;
         tick();
         wc_weight_cached = 1'b0;
         n_total++;
         if (wc_start !== 1'b0 || i2c_start !== 1'b0)
            $display("FAIL %s load_w_exit: got wc_start=%0b i2c_start=%0b want 0 0", tag, wc_start, i2c_start);
         else n_pass++;

         saw_i2c = 1'b0;
         if (hs_in_wait) begin
            out_valid = 1'b1;
            out_ready = 1'b1;
         end
         repeat ($urandom_range(1, 4)) begin
            tick();
            if (i2c_start) saw_i2c = 1'b1;
         end
         out_valid = 1'b0;
         out_ready = 1'b0;
         n_total++;
         if (saw_i2c !== 1'b0) $display("FAIL %s early_i2c: got 1 want 0", tag);
         else n_pass++;

         wc_weight_cached = 1'b1;
         tick();
         wc_weight_cached = 1'b0;
         n_total++;
         if (i2c_start !== 1'b1) $display("FAIL %s i2c_start%0d: got %0b want 1", tag, t, i2c_start);
         else n_pass++;

         beats = 0;
         guard = 0;
         early = 1'b0;
         while (beats < orows && guard < orows * 16 + 64) begin
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 3) != 0);
            out_valid = v;
            out_ready = r;
            fin = v && r && (beats == orows - 1);
            if (t == abort_tile && fin) abort = 1'b1;
            if (poke_start && t == 0 && guard == 1) begin
               start = 1'b1;
               cfg_matrix_row = ROW_W'(row + 7);
               cfg_out_rows   = OUT_W'(orows + 3);
            end
            if (v && r) beats++;
            tick();
            start = 1'b0;
            abort = 1'b0;
            guard++;
            if (beats < orows && (done || wc_start || i2c_start || !busy)) early = 1'b1;
         end
         out_valid = 1'b0;
         out_ready = 1'b0;
         cfg_matrix_row = ROW_W'(row);
         cfg_out_rows   = OUT_W'(orows);
         n_total++;
         if (beats != orows) begin
            $display("FAIL %s beat_loop_timeout: got %0d beats want %0d", tag, beats, orows);
            return;
         end else n_pass++;
         n_total++;
         if (early !== 1'b0) $display("FAIL %s early_exit_tile%0d: got 1 want 0", tag, t);
         else n_pass++;

         if (t == abort_tile) begin
            n_total++;
            if (busy !== 1'b0 || done !== 1'b0)
               $display("FAIL %s abort_idle: got busy=%0b done=%0b want 0 0", tag, busy, done);
            else n_pass++;
            tick();
            n_total++;
            if (busy !== 1'b0 || done !== 1'b0 || wc_start !== 1'b0 || tile_idx !== '0)
               $display("FAIL %s abort_after: got busy=%0b done=%0b wc_start=%0b tile=%0d want 0 0 0 0",
                        tag, busy, done, wc_start, tile_idx);
            else n_pass++;
            return;
         end

         n_total++;
         if (done !== (t == n - 1)) $display("FAIL %s done_tile%0d: got %0b want %0b", tag, t, done, (t == n - 1));
         else n_pass++;
         tick();
         if (t == n - 1) begin
            n_total++;
            if (busy !== 1'b0 || done !== 1'b0)
               $display("FAIL %s after_done: got busy=%0b done=%0b want 0 0", tag, busy, done);
            else n_pass++;
         end
      end
   endtask

   task automatic test_reset();
      repeat (3) tick();
      n_total++;
      if (all_outs() !== '0) $display("FAIL reset_outputs: got %h want 0", all_outs());
      else n_pass++;
      reset = 1'b0;
      tick();
      n_total++;
      if (all_outs() !== '0) $display("FAIL post_reset_outputs: got %h want 0", all_outs());
      else n_pass++;
   endtask

   task automatic test_bad_config();
      for (int k = 0; k < 3; k++) begin
         cfg_matrix_row = (k == 0) ? '0 : ROW_W'(288);
         cfg_matrix_col = (k == 1) ? '0 : ROW_W'(20);
         cfg_out_rows   = (k == 2) ? '0 : OUT_W'(5);
         start = 1'b1;
         tick();
         start = 1'b0;
         n_total++;
         if (cfg_err !== 1'b1 || busy !== 1'b0 || wc_start !== 1'b0)
            $display("FAIL bad_cfg%0d: got err=%0b busy=%0b wc_start=%0b want 1 0 0", k, cfg_err, busy, wc_start);
         else n_pass++;
         tick();
         n_total++;
         if (cfg_err !== 1'b0 || busy !== 1'b0 || wc_start !== 1'b0)
            $display("FAIL bad_cfg%0d_after: got err=%0b busy=%0b wc_start=%0b want 0 0 0", k, cfg_err, busy, wc_start);
         else n_pass++;
      end
   endtask

   task automatic test_async_reset();
      cfg_matrix_row = ROW_W'(288);
      cfg_matrix_col = ROW_W'(16);
      cfg_out_rows   = OUT_W'(4);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      n_total++;
      if (busy !== 1'b1) $display("FAIL async_pre_busy: got %0b want 1", busy);
      else n_pass++;
      #2 reset = 1'b1;
      #1;
      n_total++;
      if (all_outs() !== '0) $display("FAIL async_reset_outputs: got %h want 0", all_outs());
      else n_pass++;
      out_valid = 1'b1;
      out_ready = 1'b1;
      wc_weight_cached = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      out_valid = 1'b0;
      out_ready = 1'b0;
      wc_weight_cached = 1'b0;
      tick();
      n_total++;
      if (all_outs() !== '0) $display("FAIL async_after_release: got %h want 0", all_outs());
      else n_pass++;
      run_layer(288, 16, 4, -1, 1'b0, 1'b0, "post_reset");
   endtask

   initial begin
      test_reset();
      run_layer(288, 32, 300, -1, 1'b1, 1'b1, "nominal");
      run_layer(27, 20, 5, -1, 1'b0, 1'b1, "remainder");
      test_bad_config();
      run_layer(27, 20, 5, 1, 1'b0, 1'b0, "abort");
      run_layer(27, 20, 5, -1, 1'b0, 1'b0, "restart");
      test_async_reset();
      for (int i = 0; i < 4; i++)
         run_layer($urandom_range(1, 300), $urandom_range(1, 40), $urandom_range(1, 12),
                   -1, 1'b0, 1'b1, "random");
      run_layer(9, 8, 1, -1, 1'b0, 1'b0, "single_beat");
      run_layer(9, 1, 3, -1, 1'b0, 1'b0, "one_col");
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
